// File: rtl/gf2m_pkg.sv
// gf2m_pkg: shared GF(2^233) field constants, FSM encoding and latency for the serial multiplier
// Build option: GF2M_MULT_DIGIT2_EN selects two multiplier bits per cycle (latency ceil(N/2))
package gf2m_pkg;
  localparam int N = 233;
  localparam int CW = 8;
  localparam logic [N-1:0] F_LOW = N'(1) | (N'(1) << 74);
`ifdef GF2M_MULT_DIGIT2_EN
  localparam int LAT = (N + 1) / 2;
`else
  localparam int LAT = N;
`endif
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
endpackage

// File: rtl/gf2m_mulx.sv
// gf2m_mulx: combinational multiply-by-x modulo f(x) = x^233 + x^74 + 1
// Ports: v = field element in, y = v*x mod f out
module gf2m_mulx
  import gf2m_pkg::*;
(
  input  logic [N-1:0] v,
  output logic [N-1:0] y
);
  assign y = {v[N-2:0], 1'b0} ^ (v[N-1] ? F_LOW : '0);
endmodule

// File: rtl/gf2m_mult_serial.sv
// gf2m_mult_serial: bit-serial MSB-first GF(2^233) multiplier, C = A*B mod f(x)
// Ports: clk, rst_n (async active-low), start strobe, a/b operands in,
//        busy while iterating, done one-cycle pulse with c valid, c product out
// Build option: GF2M_MULT_DIGIT2_EN processes two bits of a per cycle
module gf2m_mult_serial
  import gf2m_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] c
);
  state_t state, state_nxt;
  logic [N-1:0] a_q, b_q, acc, acc_x, acc_nxt;
  logic [CW-1:0] cnt;
  logic accept;
  gf2m_mulx u_x0 (.v(acc), .y(acc_x));
`ifdef GF2M_MULT_DIGIT2_EN
  // a is zero-extended to N+1 bits; cnt indexes bit pairs, high bit first.
  // mulx is linear, so mulx(mulx(acc)) ^ hi*mulx(B) folds into mulx(mulx(acc) ^ hi*B).
  logic [1:0] a_pair;
  logic [N-1:0] mid, mid_x;
  assign a_pair = 2'({1'b0, a_q} >> {cnt, 1'b0});
  assign mid = acc_x ^ (a_pair[1] ? b_q : '0);
  gf2m_mulx u_x1 (.v(mid), .y(mid_x));
  assign acc_nxt = mid_x ^ (a_pair[0] ? b_q : '0);
`else
  assign acc_nxt = acc_x ^ (a_q[cnt] ? b_q : '0);
`endif
  always_comb begin
    accept = start && (state != RUN);
    state_nxt = (state == RUN) ? ((cnt == '0) ? FIN : RUN) : (start ? RUN : IDLE);
    busy = (state == RUN);
    done = (state == FIN);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      cnt <= '0;
      c <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q <= a;
        b_q <= b;
        acc <= '0;
        cnt <= CW'(LAT - 1);
      end else if (state == RUN) begin
        acc <= acc_nxt;
        if (cnt != '0) cnt <= cnt - 1'b1;
        else c <= acc_nxt;
      end
    end
  end
endmodule

// File: doc/gf2m_mult_serial.md
# gf2m_mult_serial

Bit-serial multiplier over GF(2^N), N = 233, reduction polynomial f(x) = x^233 + x^74 + 1 (NIST B-233/K-233 field). It is the arithmetic stage directly upstream of the ECC datapath operand/result registers. It accepts two field elements on a start strobe, iterates one multiplier bit per clock (MSB first), and presents the reduced product with a one-cycle DONE pulse. DONE is wired straight to the downstream register's LOAD input.

## Interface
- N, 233, field degree and operand/product width
- F_LOW, N-bit constant with bits 74 and 0 set, low terms of f(x) (x^N term implicit)
- CW, 8, iteration counter width, ceil(log2(N+1))

Ports:
- CLK  in  1  rising-edge clock; the only clock
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  request; sampled only in IDLE or DONE state
- A  in  N  multiplicand (scanned bit-serially), captured on accepted START
- B  in  N  multiplier operand, captured on accepted START
- BUSY  out  1  high while iterating
- DONE  out  1  one-cycle pulse; C valid; drives downstream LOAD
- C  out  N  product A·B mod f(x)

## Operation
- FSM states:
  - IDLE: BUSY=0, DONE=0.
  - RUN: BUSY=1.
  - FIN: DONE=1 for exactly one cycle.
- Transitions:
  - IDLE: START=1 → RUN, else stay in IDLE.
  - RUN: counter reaches terminal → FIN.
  - FIN: START=1 → RUN (back-to-back accepted), else → IDLE.
- On accepted START:
  - A and B are latched into internal registers.
  - Accumulator is cleared to 0.
  - Counter is loaded with the first bit index.
- Per RUN cycle (bit-serial, MSB first):
  - acc ← mulx(acc) ⊕ (a_i ? B : 0).
  - mulx(v) = (v << 1)[N-1:0] ⊕ (v[N-1] ? F_LOW : 0).
  - Counter decrements by 1 per cycle.
- All arithmetic is XOR only; no carries. Widths stay at exactly N bits after every step.
- C is a registered copy of the accumulator. It updates only on the transition RUN→FIN and holds its value until the next FIN. The accumulator is internal.
- START asserted in RUN is ignored: no restart, operands are not re-latched.
- A/B changes after START acceptance have no effect.
- Reset values:
  - State = IDLE, BUSY=0, DONE=0, C=0, counter=0.
  - Internal operand copies and accumulator = 0.
- Reset assertion mid-operation aborts immediately (asynchronously). No DONE pulse is produced for the aborted operation.

## Timing
- START high at rising edge k (state IDLE/FIN) → BUSY=1 from edge k.
- Default build: RUN lasts N=233 edges (k+1 … k+233). FIN is entered at edge k+233; DONE=1 and C valid during cycle k+233 → k+234.
- START→DONE latency = N cycles. Back-to-back throughput = one product per N+1 cycles (START held high in FIN).
- Downstream register loads C at edge k+234, i.e. the edge that closes the DONE cycle.
- BUSY falls at the FIN entry edge; BUSY and DONE are never high together.

## Configuration
- GF2M_MULT_DIGIT2_EN:
  - When defined, two bits of A are processed per cycle: acc ← mulx(mulx(acc)) ⊕ (a_i ? mulx(B) : 0) ⊕ (a_{i-1} ? B : 0).
  - A is zero-extended to N+1 bits at the MSB.
  - RUN lasts ceil(N/2)=117 cycles; START→DONE latency = 117.
- When undefined: single-bit datapath as above, latency N.
- Handshake, reset behaviour and product value are identical in both builds.

## Structure
- Shared package gf2m_pkg:
  - Field parameters N and F_LOW.
  - Counter width CW.
  - FSM state encoding (IDLE, RUN, FIN) as a typedef'd enum.
  - The compile-time latency constant (N or ceil(N/2)).
- One sub-module: gf2m_mulx. It is purely combinational, takes an N-bit input and produces v·x mod f. It is instantiated once (twice with GF2M_MULT_DIGIT2_EN), and is reused later by the squarer.

## Test plan
- Identity: A=1, B=0x1234_5678 → C=0x1234_5678 after N cycles; DONE high exactly 1 cycle; BUSY low during DONE.
- Reduction: A=2 (x), B=x^232 (bit 232 set) → C has only bits 74 and 0 set.
- Zero/wrap: A=0 with any B → C=0. A=B=all-ones → C matches the golden carry-less multiply-and-reduce model.
- START pulsed again 10 cycles into RUN with different operands → ignored; DONE at the original latency with the first product.
- Back-to-back: START held high through FIN with new operands → second DONE exactly N+1 cycles after the first; both products correct.
- Reset mid-run: RST_N low at cycle 50 → BUSY/DONE/C read 0 immediately; no DONE pulse; the next START yields a correct product. Repeat all scenarios with GF2M_MULT_DIGIT2_EN (latency 117) and 1000 random operand pairs against the model.
